banco_rf_param: RTL and testbench

Parametrised successor to the team's 32x32 register bank (`Banco`), for the pipelined datapath. It keeps combinational reads and clocked writes. It adds four things: configurable width, depth and zero register; async clearing reset; same-cycle write-to-read bypass; and a per-register busy scoreboard. The scoreboard lets the issue stage reserve a destination register and see whether each operand is ready.

---
 rtl/banco_rf_param.sv | 108 ++++++++++
 tb/tb_banco_rf_param.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banco_rf_param.sv
// Parametrised register bank: combinational dual read, clocked single write,
// optional zero register, same-cycle write-to-read bypass and per-register busy scoreboard.
module banco_rf_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    DL1,
  input  logic [AW-1:0]    DL2,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] op2,
  output logic             ok1,
  output logic             ok2,
  input  logic [AW-1:0]    DE,
  input  logic [WIDTH-1:0] Dato,
  input  logic             WE,
  input  logic             RSV,
  input  logic [AW-1:0]    DR,
  output logic             rsv_stall,
  output logic [DEPTH-1:0] busy
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             we_v;
  logic             rsv_v;
  logic             rsv_acc;
  logic [IW-1:0]    de_i;
  logic [IW-1:0]    dr_i;
  logic [IW-1:0]    dl1_i;
  logic [IW-1:0]    dl2_i;

  // Out-of-range addresses and the hardwired zero register are inert.
  function automatic logic ignorable(input logic [AW-1:0] a);
    return (32'(a) >= DEPTH_U) || ((ZERO_REG != 0) && (a == '0));
  endfunction

  assign de_i  = DE[IW-1:0];
  assign dr_i  = DR[IW-1:0];
  assign dl1_i = DL1[IW-1:0];
  assign dl2_i = DL2[IW-1:0];

  // Every input is qualified by rst_n so reset forces the idle output values.
  assign we_v      = rst_n && WE && !ignorable(DE);
  assign rsv_v     = rst_n && RSV && !ignorable(DR);
  assign rsv_stall = rsv_v && busy_q[dr_i] && !(we_v && (DE == DR));
  assign rsv_acc   = rsv_v && !rsv_stall;

  // The reserve is applied after the write clear so a new reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (we_v)    busy_d[de_i] = 1'b0;
    if (rsv_acc) busy_d[dr_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we_v) begin
      mem[de_i] <= Dato;
    end
  end

  always_comb begin
    op1 = '0;
    ok1 = 1'b1;
    if (rst_n && !ignorable(DL1)) begin
      if ((BYPASS != 0) && we_v && (DE == DL1)) begin
        op1 = Dato;
      end else begin
        op1 = mem[dl1_i];
        ok1 = !busy_q[dl1_i];
      end
    end
  end

  always_comb begin
    op2 = '0;
    ok2 = 1'b1;
    if (rst_n && !ignorable(DL2)) begin
      if ((BYPASS != 0) && we_v && (DE == DL2)) begin
        op2 = Dato;
      end else begin
        op2 = mem[dl2_i];
        ok2 = !busy_q[dl2_i];
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_banco_rf_param.sv
// Bench for banco_rf_param: three configurations driven in parallel, every output
// compared each cycle against a rule-level reference model through an expected queue.
module tb_banco_rf_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- stimulus per instance (0: default, 1: D16/Z0/no bypass, 2: W64/D8) ----
  logic [4:0]  dl1 [3];
  logic [4:0]  dl2 [3];
  logic [4:0]  de  [3];
  logic [4:0]  dr  [3];
  logic [63:0] dato[3];
  logic        we  [3];
  logic        rsv [3];

  logic [31:0] a_op1, a_op2, b_op1, b_op2;
  logic [63:0] c_op1, c_op2;
  logic        a_ok1, a_ok2, b_ok1, b_ok2, c_ok1, c_ok2;
  logic        a_stall, b_stall, c_stall;
  logic [31:0] a_busy;
  logic [15:0] b_busy;
  logic [7:0]  c_busy;

  banco_rf_param u_a (
    .clk(clk), .rst_n(rst_n), .DL1(dl1[0]), .DL2(dl2[0]), .op1(a_op1), .op2(a_op2),
    .ok1(a_ok1), .ok2(a_ok2), .DE(de[0]), .Dato(dato[0][31:0]), .WE(we[0]),
    .RSV(rsv[0]), .DR(dr[0]), .rsv_stall(a_stall), .busy(a_busy)
  );

  banco_rf_param #(.DEPTH(16), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .DL1(dl1[1]), .DL2(dl2[1]), .op1(b_op1), .op2(b_op2),
    .ok1(b_ok1), .ok2(b_ok2), .DE(de[1]), .Dato(dato[1][31:0]), .WE(we[1]),
    .RSV(rsv[1]), .DR(dr[1]), .rsv_stall(b_stall), .busy(b_busy)
  );

  banco_rf_param #(.WIDTH(64), .DEPTH(8), .AW(3)) u_c (
    .clk(clk), .rst_n(rst_n), .DL1(dl1[2][2:0]), .DL2(dl2[2][2:0]), .op1(c_op1), .op2(c_op2),
    .ok1(c_ok1), .ok2(c_ok2), .DE(de[2][2:0]), .Dato(dato[2]), .WE(we[2]),
    .RSV(rsv[2]), .DR(dr[2][2:0]), .rsv_stall(c_stall), .busy(c_busy)
  );

  // ---------------- reference model ----------------
  int          depth_c [3] = '{32, 16, 8};
  bit          zero_c  [3] = '{1'b1, 1'b0, 1'b1};
  bit          byp_c   [3] = '{1'b1, 1'b0, 1'b1};
  logic [63:0] mask_c  [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
  logic [63:0] m_mem   [3][32];
  bit          m_busy  [3][32];

  function automatic bit m_ign(int i, int a);
    return (a >= depth_c[i]) || (zero_c[i] && a == 0);
  endfunction

  function automatic bit m_we(int i);
    return rst_n && we[i] && !m_ign(i, int'(de[i]));
  endfunction

  function automatic bit m_rsv(int i);
    return rst_n && rsv[i] && !m_ign(i, int'(dr[i]));
  endfunction

  function automatic bit m_stall(int i);
    return m_rsv(i) && m_busy[i][dr[i]] && !(m_we(i) && de[i] == dr[i]);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 32; k++) begin
        m_mem[i][k]  = '0;
        m_busy[i][k] = 1'b0;
      end
  endtask

  task automatic m_edge();
    bit st;
    if (!rst_n) return;
    for (int i = 0; i < 3; i++) begin
      st = m_stall(i);
      if (m_we(i)) begin
        m_mem[i][de[i]]  = dato[i] & mask_c[i];
        m_busy[i][de[i]] = 1'b0;
      end
      if (m_rsv(i) && !st) m_busy[i][dr[i]] = 1'b1;
    end
  endtask

  task automatic m_read(input int i, input int a, output logic [63:0] d, output logic ok);
    d  = '0;
    ok = 1'b1;
    if (!rst_n || m_ign(i, a)) return;
    if (byp_c[i] && m_we(i) && int'(de[i]) == a) begin
      d = dato[i] & mask_c[i];
    end else begin
      d  = m_mem[i][a];
      ok = !m_busy[i][a];
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int          inst;
    int          sig;
    logic [63:0] exp;
  } exp_t;
  exp_t  exp_q[$];
  string sig_name[6] = '{"op1", "op2", "ok1", "ok2", "rsv_stall", "busy"};
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic cexp(input int i, input int s, input logic [63:0] v);
    exp_t e;
    e.inst = i;
    e.sig  = s;
    e.exp  = v;
    exp_q.push_back(e);
  endtask

  task automatic push_all();
    logic [63:0] d1, d2, bv;
    logic        k1, k2;
    for (int i = 0; i < 3; i++) begin
      m_read(i, int'(dl1[i]), d1, k1);
      m_read(i, int'(dl2[i]), d2, k2);
      bv = '0;
      for (int k = 0; k < depth_c[i]; k++) bv[k] = m_busy[i][k];
      cexp(i, 0, d1);
      cexp(i, 1, d2);
      cexp(i, 2, {63'b0, k1});
      cexp(i, 3, {63'b0, k2});
      cexp(i, 4, {63'b0, m_stall(i)});
      cexp(i, 5, bv);
    end
  endtask

  function automatic logic [63:0] act(int i, int s);
    logic [63:0] r;
    r = '0;
    case (i * 8 + s)
      0:  r = {32'b0, a_op1};
      1:  r = {32'b0, a_op2};
      2:  r = {63'b0, a_ok1};
      3:  r = {63'b0, a_ok2};
      4:  r = {63'b0, a_stall};
      5:  r = {32'b0, a_busy};
      8:  r = {32'b0, b_op1};
      9:  r = {32'b0, b_op2};
      10: r = {63'b0, b_ok1};
      11: r = {63'b0, b_ok2};
      12: r = {63'b0, b_stall};
      13: r = {48'b0, b_busy};
      16: r = c_op1;
      17: r = c_op2;
      18: r = {63'b0, c_ok1};
      19: r = {63'b0, c_ok2};
      20: r = {63'b0, c_stall};
      21: r = {56'b0, c_busy};
      default: r = '1;
    endcase
    return r;
  endfunction

  // Monitor: outputs are combinational, so every queued expectation is due at this negedge.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [63:0] a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act(e.inst, e.sig);
      n_checks++;
      if (a !== e.exp) begin
        n_fail++;
        $display("FAIL %s inst=%0d t=%0t actual=%h expected=%h",
                 sig_name[e.sig], e.inst, $time, a, e.exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    for (int i = 0; i < 3; i++) begin
      dl1[i] = '0; dl2[i] = '0; de[i] = '0; dr[i] = '0;
      dato[i] = '0; we[i] = 1'b0; rsv[i] = 1'b0;
    end
  endtask

  // Queue the model's view of the current inputs, then advance through one edge.
  task automatic go();
    push_all();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  function automatic logic [4:0] raddr(int i);
    if (i == 2) return 5'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic rnd();
    for (int i = 0; i < 3; i++) begin
      dl1[i]  = raddr(i);
      dl2[i]  = raddr(i);
      de[i]   = raddr(i);
      dr[i]   = raddr(i);
      dato[i] = {$urandom, $urandom};
      we[i]   = 1'($urandom_range(0, 1));
      rsv[i]  = ($urandom_range(0, 2) == 0);
    end
  endtask

  function automatic logic [63:0] pat(int a);
    return {32'hC0DE_0000 + 32'(a), ~32'(a * 3)};
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    m_clear();
    @(posedge clk);
    #1;
    rnd();
    cexp(0, 5, 64'h0); cexp(0, 0, 64'h0); cexp(0, 2, 64'h1); cexp(0, 4, 64'h0);
    go();
    go();
    rst_n = 1'b1;

    for (int a = 0; a < 16; a++) begin
      idle();
      dl1[0] = 5'(a); dl2[0] = 5'(a + 16);
      dl1[1] = 5'(a); dl2[1] = 5'(a + 16);
      dl1[2] = 5'(a % 8); dl2[2] = 5'(7 - a % 8);
      cexp(0, 0, 64'h0); cexp(0, 3, 64'h1);
      go();
    end

    idle(); we[0] = 1'b1; de[0] = 5'd5; dato[0] = 64'hDEAD_BEEF; go();
    idle(); dl1[0] = 5'd5; cexp(0, 0, 64'hDEAD_BEEF); go();
    idle(); dl1[0] = 5'd5; rst_n = 1'b0; m_clear(); cexp(0, 0, 64'h0); go();
    rst_n = 1'b1;
    idle(); dl1[0] = 5'd5; cexp(0, 0, 64'h0); go();

    idle(); we[0] = 1'b1; de[0] = 5'd0; dato[0] = 64'h1234; go();
    idle(); dl1[0] = 5'd0; rsv[0] = 1'b1; dr[0] = 5'd0;
    cexp(0, 0, 64'h0); cexp(0, 4, 64'h0); go();
    idle(); cexp(0, 5, 64'h0); go();

    idle(); we[1] = 1'b1; de[1] = 5'd20; dato[1] = 64'h5555_5555; go();
    idle(); dl1[1] = 5'd20; cexp(1, 0, 64'h0); cexp(1, 2, 64'h1); cexp(1, 5, 64'h0); go();

    idle(); we[0] = 1'b1; de[0] = 5'd3; dato[0] = 64'hA5A5_A5A5; dl1[0] = 5'd3; dl2[0] = 5'd3;
    cexp(0, 0, 64'hA5A5_A5A5); cexp(0, 1, 64'hA5A5_A5A5); cexp(0, 2, 64'h1); go();

    idle(); we[1] = 1'b1; de[1] = 5'd3; dato[1] = 64'h11; go();
    idle(); we[1] = 1'b1; de[1] = 5'd3; dato[1] = 64'hA5A5_A5A5; dl1[1] = 5'd3; dl2[1] = 5'd3;
    cexp(1, 0, 64'h11); cexp(1, 1, 64'h11); go();
    idle(); dl1[1] = 5'd3; cexp(1, 0, 64'hA5A5_A5A5); go();

    idle(); rsv[0] = 1'b1; dr[0] = 5'd7; cexp(0, 4, 64'h0); go();
    idle(); dl1[0] = 5'd7; rsv[0] = 1'b1; dr[0] = 5'd7;
    cexp(0, 2, 64'h0); cexp(0, 4, 64'h1); cexp(0, 5, 64'h80); go();
    idle(); we[0] = 1'b1; de[0] = 5'd7; dato[0] = 64'h77; go();
    idle(); dl1[0] = 5'd7; cexp(0, 2, 64'h1); cexp(0, 0, 64'h77); cexp(0, 5, 64'h0); go();

    idle(); rsv[0] = 1'b1; dr[0] = 5'd9; go();
    idle(); we[0] = 1'b1; de[0] = 5'd9; dato[0] = 64'h99; rsv[0] = 1'b1; dr[0] = 5'd9;
    cexp(0, 4, 64'h0); go();
    idle(); dl1[0] = 5'd9;
    cexp(0, 0, 64'h99); cexp(0, 2, 64'h0); cexp(0, 5, 64'h200); go();

    idle(); we[0] = 1'b1; de[0] = 5'd4; dato[0] = 64'h44; rsv[0] = 1'b1; dr[0] = 5'd6; go();
    idle(); dl1[0] = 5'd4; dl2[0] = 5'd6;
    cexp(0, 0, 64'h44); cexp(0, 2, 64'h1); cexp(0, 3, 64'h0); cexp(0, 5, 64'h240); go();

    for (int a = 0; a < 8; a++) begin
      idle(); we[2] = 1'b1; de[2] = 5'(a); dato[2] = pat(a); go();
    end
    for (int a = 0; a < 8; a++) begin
      idle(); dl1[2] = 5'(a); dl2[2] = 5'(7 - a);
      cexp(2, 0, (a == 0) ? 64'h0 : pat(a));
      cexp(2, 1, (a == 7) ? 64'h0 : pat(7 - a));
      go();
    end

    for (int n = 0; n < 800; n++) begin
      rnd();
      if ($urandom_range(0, 79) == 0) begin
        rst_n = 1'b0;
        m_clear();
        go();
        rst_n = 1'b1;
      end else begin
        go();
      end
    end

    idle();
    go();
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
